coinc_seq_ctrl: RTL and testbench

COINC_SEQ_CTRL -- requirements
Module: coinc_seq_ctrl

---
 rtl/coinc_seq_ctrl_pkg.sv | 28 ++
 rtl/coinc_seq_ctrl_readout_buf.sv | 62 ++++++
 rtl/coinc_seq_ctrl.sv | 139 +++++++++++++
 tb/tb_coinc_seq_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coinc_seq_ctrl_pkg.sv
// Shared types and sizing helpers for the coincidence sequencer.
// Pair count is n*(n-1)/2; index width never collapses below 1.
package coinc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ARM,
    ACQ,
    DRAIN,
    SNAP,
    READ
  } state_t;

  localparam int DEF_NCHAN = 4;
  localparam int DEF_NBITS = 4;

  typedef logic [DEF_NCHAN-1:0][DEF_NBITS-1:0] dly_arr_t;

  function automatic int ncomb(input int n);
    return n * (n - 1) / 2;
  endfunction

  function automatic int iwidth(input int n);
    return (ncomb(n) > 1) ? $clog2(ncomb(n)) : 1;
  endfunction

endpackage

// File: rtl/coinc_seq_ctrl_readout_buf.sv
// Snapshot of detector pair counts plus a valid/ready word sequencer.
// Shadow copy decouples readout from the live counters.
module coinc_readout_buf
  import coinc_pkg::*;
#(
  parameter int NBITS  = 4,
  parameter int NCOMB  = 6,
  parameter int IWIDTH = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        snap,
  input  logic                        flush,
  input  logic [NCOMB-1:0][NBITS-1:0] counts,
  input  logic                        rd_ready,
  output logic [NBITS-1:0]            rd_data,
  output logic [IWIDTH-1:0]           rd_idx,
  output logic                        rd_valid,
  output logic                        rd_last,
  output logic                        ovf
);

  logic [NCOMB-1:0][NBITS-1:0] shadow;
  logic                        sat;
  logic                        xfer;

  always_comb begin
    sat = 1'b0;
    for (int k = 0; k < NCOMB; k++) begin
      if (counts[k] == '1) sat = 1'b1;
    end
  end

  assign xfer    = rd_valid & rd_ready;
  assign rd_last = xfer & (rd_idx == IWIDTH'(NCOMB - 1));
  assign rd_data = shadow[rd_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow   <= '0;
      rd_idx   <= '0;
      rd_valid <= 1'b0;
      ovf      <= 1'b0;
    end else if (flush) begin
      rd_valid <= 1'b0;
      rd_idx   <= '0;
    end else if (snap) begin
      shadow   <= counts;
      ovf      <= sat;
      rd_idx   <= '0;
      rd_valid <= 1'b1;
    end else if (xfer) begin
      if (rd_last) begin
        rd_valid <= 1'b0;
        rd_idx   <= '0;
      end else begin
        rd_idx <= rd_idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/coinc_seq_ctrl.sv
// Run sequencer for a coincidence detector: clear, flush, gate,
// drain, snapshot and stream out the pair counters.
module coinc_seq_ctrl
  import coinc_pkg::*;
#(
  parameter  int NCHAN  = 4,
  parameter  int NBITS  = 4,
  parameter  int NREGS  = 4,
  parameter  int WWIDTH = 16,
  localparam int NCOMB  = ncomb(NCHAN),
  localparam int IWIDTH = iwidth(NCHAN)
) (
  input  logic                        Clk,
  input  logic                        Rst_n,
  input  logic                        Start,
  input  logic                        Abort,
  input  logic [WWIDTH-1:0]           WindowLen,
  input  logic [NCHAN-1:0][NBITS-1:0] DelaysCfg,
  input  logic [NCHAN-1:0]            ChanIn,
  input  logic [NCOMB-1:0][NBITS-1:0] Counts,
  output logic [NCHAN-1:0]            ChanOut,
  output logic [NCHAN-1:0][NBITS-1:0] DelaysOut,
  output logic                        DetClr,
  output logic [NBITS-1:0]            RdData,
  output logic [IWIDTH-1:0]           RdIdx,
  output logic                        RdValid,
  input  logic                        RdReady,
  output logic                        Busy,
  output logic                        Done,
  output logic                        Ovf
);

  localparam logic [WWIDTH-1:0] FLUSH_M1 = WWIDTH'(NREGS - 1);

  state_t            state;
  logic [WWIDTH-1:0] cnt;
  logic [WWIDTH-1:0] winm1;
  logic              aborting;
  logic              rd_last;
  logic              flush;

  assign flush   = Abort & (state != IDLE);
  assign ChanOut = (state == ACQ) ? ChanIn : '0;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      winm1     <= '0;
      aborting  <= 1'b0;
      DelaysOut <= '0;
      DetClr    <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
    end else begin
      DetClr <= 1'b0;
      Done   <= 1'b0;
      if (flush) begin
        // Abandoned runs still clear the counters before idling.
        state    <= CLEAR;
        aborting <= 1'b1;
        DetClr   <= 1'b1;
        Busy     <= 1'b1;
      end else begin
        unique case (state)
          IDLE: begin
            if (Start && !Abort) begin
              state     <= CLEAR;
              aborting  <= 1'b0;
              DetClr    <= 1'b1;
              Busy      <= 1'b1;
              DelaysOut <= DelaysCfg;
              winm1     <= (WindowLen == '0) ? '0
                                             : WindowLen - 1'b1;
            end
          end
          CLEAR: begin
            if (aborting) begin
              state    <= IDLE;
              aborting <= 1'b0;
              Busy     <= 1'b0;
            end else begin
              state <= ARM;
              cnt   <= FLUSH_M1;
            end
          end
          ARM: begin
            if (cnt == '0) begin
              state <= ACQ;
              cnt   <= winm1;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          ACQ: begin
            if (cnt == '0) begin
              state <= DRAIN;
              cnt   <= FLUSH_M1;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          DRAIN: begin
            if (cnt == '0) state <= SNAP;
            else           cnt   <= cnt - 1'b1;
          end
          SNAP: state <= READ;
          READ: begin
            if (rd_last) begin
              state <= IDLE;
              Busy  <= 1'b0;
              Done  <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  coinc_readout_buf #(
    .NBITS  (NBITS),
    .NCOMB  (NCOMB),
    .IWIDTH (IWIDTH)
  ) u_buf (
    .clk      (Clk),
    .rst_n    (Rst_n),
    .snap     (state == SNAP),
    .flush    (flush),
    .counts   (Counts),
    .rd_ready (RdReady),
    .rd_data  (RdData),
    .rd_idx   (RdIdx),
    .rd_valid (RdValid),
    .rd_last  (rd_last),
    .ovf      (Ovf)
  );

endmodule

// File: tb/tb_coinc_seq_ctrl.sv
// Directed bench for coinc_seq_ctrl: timing, stalls, abort,
// ignored starts, saturation and mid-run reset.
module tb_coinc_seq_ctrl;
  import coinc_pkg::*;

  localparam int NCHAN  = 4;
  localparam int NBITS  = 4;
  localparam int NREGS  = 4;
  localparam int WWIDTH = 16;
  localparam int NCOMB  = 6;
  localparam int IWIDTH = 3;

  logic                        Clk = 1'b0;
  logic                        Rst_n = 1'b1;
  logic                        Start = 1'b0;
  logic                        Abort = 1'b0;
  logic                        RdReady = 1'b0;
  logic [WWIDTH-1:0]           WindowLen = '0;
  dly_arr_t                    DelaysCfg = '0;
  logic [NCHAN-1:0]            ChanIn = '0;
  logic [NCOMB-1:0][NBITS-1:0] Counts = '0;
  logic [NCHAN-1:0]            ChanOut;
  logic [NCHAN-1:0][NBITS-1:0] DelaysOut;
  logic                        DetClr;
  logic [NBITS-1:0]            RdData;
  logic [IWIDTH-1:0]           RdIdx;
  logic                        RdValid;
  logic                        Busy;
  logic                        Done;
  logic                        Ovf;

  int checks   = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  coinc_seq_ctrl #(
    .NCHAN  (NCHAN),
    .NBITS  (NBITS),
    .NREGS  (NREGS),
    .WWIDTH (WWIDTH)
  ) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .Start     (Start),
    .Abort     (Abort),
    .WindowLen (WindowLen),
    .DelaysCfg (DelaysCfg),
    .ChanIn    (ChanIn),
    .Counts    (Counts),
    .ChanOut   (ChanOut),
    .DelaysOut (DelaysOut),
    .DetClr    (DetClr),
    .RdData    (RdData),
    .RdIdx     (RdIdx),
    .RdValid   (RdValid),
    .RdReady   (RdReady),
    .Busy      (Busy),
    .Done      (Done),
    .Ovf       (Ovf)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"}, Busy, 0);
    chk({tag, "_dly"}, DelaysOut, 0);
    chk({tag, "_clr"}, DetClr, 0);
    chk({tag, "_rv"}, RdValid, 0);
    chk({tag, "_ri"}, RdIdx, 0);
    chk({tag, "_rd"}, RdData, 0);
    chk({tag, "_done"}, Done, 0);
    chk({tag, "_ovf"}, Ovf, 0);
    chk({tag, "_chan"}, ChanOut, 0);
  endtask

  initial begin
    int clr_n, clr_first, act_n, act_first, act_last;
    int rv_first, words, done_n, done_cyc, busy_n, ph;
    logic pv, pr;
    logic [IWIDTH-1:0] pi;
    logic [NBITS-1:0] pd;
    logic [NBITS-1:0] exp_w [NCOMB];

    // reset state
    ChanIn = 4'hF;
    #2 Rst_n = 1'b0;
    #10;
    chk_reset("rst");
    Rst_n = 1'b1;
    tick();

    // basic run, window 10
    DelaysCfg = 16'h1122;
    WindowLen = 16'd10;
    Counts    = 24'h654321;
    RdReady   = 1'b1;
    Start     = 1'b1;
    tick();
    Start = 1'b0;
    clr_n = 0; clr_first = -1; act_n = 0; act_first = -1;
    act_last = -1; rv_first = -1; words = 0; done_n = 0;
    done_cyc = -1;
    for (int c = 1; c <= 35; c++) begin
      if (c == 1) chk("t1_busy", Busy, 1);
      if (DetClr) begin
        clr_n++;
        if (clr_first < 0) clr_first = c;
      end
      if (ChanOut == 4'hF) begin
        act_n++;
        if (act_first < 0) act_first = c;
        act_last = c;
      end
      if (RdValid && RdReady) begin
        if (rv_first < 0) rv_first = c;
        chk("t1_idx", RdIdx, words);
        chk("t1_data", RdData, words + 1);
        words++;
      end
      if (Done) begin
        done_n++;
        done_cyc = c;
        chk("t1_busy_done", Busy, 0);
      end
      tick();
    end
    chk("t1_clr_n", clr_n, 1);
    chk("t1_clr_cyc", clr_first, 1);
    chk("t1_act_n", act_n, 10);
    chk("t1_act_first", act_first, 6);
    chk("t1_act_last", act_last, 15);
    chk("t1_rv_first", rv_first, 21);
    chk("t1_words", words, 6);
    chk("t1_done_n", done_n, 1);
    chk("t1_done_cyc", done_cyc, 27);
    chk("t1_ovf", Ovf, 0);
    chk("t1_dly", DelaysOut, 16'h1122);

    // stalled readout, saturated word, ignored start
    exp_w = '{4'h3, 4'h5, 4'hF, 4'h7, 4'h9, 4'hA};
    Counts    = 24'hA97F53;
    WindowLen = 16'd2;
    Start     = 1'b1;
    tick();
    Start = 1'b0;
    words = 0; ph = 0; done_n = 0; rv_first = -1;
    pv = 1'b0; pr = 1'b0; pi = '0; pd = '0;
    for (int c = 1; c <= 80; c++) begin
      if (RdValid) begin
        if (rv_first < 0) begin
          rv_first = c;
          chk("t2_ovf", Ovf, 1);
          Counts    = '0;
          DelaysCfg = 16'h7777;
          Start     = 1'b1;
        end else begin
          Start = 1'b0;
        end
        RdReady = (ph == 0) || (ph == 3);
        ph = (ph + 1) % 4;
        if (pv && !pr) begin
          chk("t2_hold_idx", RdIdx, pi);
          chk("t2_hold_data", RdData, pd);
        end
        if (RdReady) begin
          chk("t2_idx", RdIdx, words);
          chk("t2_data", RdData,
              (words < NCOMB) ? exp_w[words] : 4'h0);
          words++;
        end
        chk("t2_dly_read", DelaysOut, 16'h1122);
      end else begin
        Start = 1'b0;
      end
      pv = RdValid; pr = RdReady; pi = RdIdx; pd = RdData;
      if (Done) begin
        done_n++;
        break;
      end
      tick();
    end
    Start = 1'b0;
    RdReady = 1'b1;
    chk("t2_rv_first", rv_first, 13);
    chk("t2_words", words, 6);
    chk("t2_done", done_n, 1);
    chk("t2_busy", Busy, 0);
    chk("t2_dly_idle", DelaysOut, 16'h1122);
    tick();
    chk("t2_no_restart", Busy, 0);

    // abort on 3rd acquisition cycle
    WindowLen = 16'd10;
    ChanIn    = 4'b1010;
    Start     = 1'b1;
    tick();
    Start = 1'b0;
    chk("t3_dly_new", DelaysOut, 16'h7777);
    for (int c = 1; c < 8; c++) tick();
    chk("t3_gate", ChanOut, 4'b1010);
    Abort = 1'b1;
    tick();
    Abort = 1'b0;
    chk("t3_clr", DetClr, 1);
    chk("t3_busy_clr", Busy, 1);
    chk("t3_chan", ChanOut, 0);
    tick();
    chk("t3_busy_idle", Busy, 0);
    chk("t3_clr_off", DetClr, 0);
    done_n = 0; busy_n = 0;
    for (int c = 0; c < 30; c++) begin
      if (Done) done_n++;
      if (Busy || RdValid) busy_n++;
      tick();
    end
    chk("t3_done_n", done_n, 0);
    chk("t3_busy_n", busy_n, 0);

    // abort beats start in idle
    Abort = 1'b1;
    Start = 1'b1;
    tick();
    Abort = 1'b0;
    Start = 1'b0;
    chk("t3_idle_busy", Busy, 0);
    chk("t3_idle_clr", DetClr, 0);

    // reset in the middle of drain
    WindowLen = 16'd3;
    DelaysCfg = 16'h3456;
    Start     = 1'b1;
    tick();
    Start = 1'b0;
    for (int c = 1; c < 10; c++) tick();
    chk("t4_busy", Busy, 1);
    chk("t4_ovf_pre", Ovf, 1);
    #2 Rst_n = 1'b0;
    #1;
    chk_reset("t4rst");
    #3 Rst_n = 1'b1;
    tick();
    chk("t4_idle", Busy, 0);

    // clean run after reset, window 0 acts as 1
    WindowLen = 16'd0;
    DelaysCfg = 16'h9ABC;
    ChanIn    = 4'hF;
    Counts    = 24'h123456;
    Start     = 1'b1;
    tick();
    Start = 1'b0;
    chk("t4_clr", DetClr, 1);
    chk("t4_dly", DelaysOut, 16'h9ABC);
    act_n = 0; act_first = -1; words = 0; done_cyc = -1;
    for (int c = 1; c <= 30; c++) begin
      if (ChanOut == 4'hF) begin
        act_n++;
        if (act_first < 0) act_first = c;
      end
      if (RdValid && RdReady) begin
        chk("t4_data", RdData, 6 - words);
        words++;
      end
      if (Done) done_cyc = c;
      tick();
    end
    chk("t4_act_n", act_n, 1);
    chk("t4_act_first", act_first, 6);
    chk("t4_words", words, 6);
    chk("t4_done_cyc", done_cyc, 18);
    chk("t4_ovf", Ovf, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
